// File: rtl/seu_stream.sv
// seu_stream: per-operand sign-extension / conversion unit feeding a 2-entry
// output FIFO, with a saturating counter of sign-magnitude negative zeros.
module seu_stream #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_negzero,
  output logic [7:0]       nz_count
);

  // Reject illegal width combinations at elaboration time.
  if (IN_W < 2 || IN_W > 31 || OUT_W <= IN_W) begin : g_bad_params
    $error("seu_stream: requires 2 <= IN_W <= 31 and OUT_W > IN_W");
  end

  typedef enum logic [1:0] {
    MODE_SM  = 2'b00,
    MODE_TC  = 2'b01,
    MODE_ZX  = 2'b10,
    MODE_ABS = 2'b11
  } mode_e;

  typedef struct packed {
    logic             negzero;
    logic [OUT_W-1:0] data;
  } entry_t;

  logic             sgn;
  logic [IN_W-2:0]  mag;
  logic [OUT_W-1:0] mag_ext, sx, zx;
  entry_t           conv;

  entry_t     mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       push, pop;

  assign sgn     = in_data[IN_W-1];
  assign mag     = in_data[IN_W-2:0];
  assign mag_ext = {{(OUT_W-IN_W+1){1'b0}}, mag};
  assign sx      = {{(OUT_W-IN_W){sgn}}, in_data};
  assign zx      = {{(OUT_W-IN_W){1'b0}}, in_data};

  // Convert the offered operand; only its own in_mode matters.
  // ABS of the most negative input is exact since OUT_W > IN_W.
  always_comb begin
    conv = '0;
    case (mode_e'(in_mode))
      MODE_SM: begin
        if (!sgn)            conv.data    = mag_ext;
        else if (mag == '0)  conv.negzero = 1'b1;
        else                 conv.data    = -mag_ext;
      end
      MODE_TC:  conv.data = sx;
      MODE_ZX:  conv.data = zx;
      MODE_ABS: conv.data = sgn ? -sx : sx;
      default:  conv = '0;
    endcase
  end

  // Ready depends on registered occupancy only, so no path from out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is forced to zero when empty so idle outputs are clean.
  assign out_data    = out_valid ? mem[rd_ptr].data    : '0;
  assign out_negzero = out_valid ? mem[rd_ptr].negzero : 1'b0;

  // FIFO storage, pointers and occupancy; reset drops everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= conv;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Count accepted SM negative zeros, sticking at 255.
  always_ff @(posedge clk) begin
    if (rst)                                        nz_count <= 8'd0;
    else if (push && conv.negzero && nz_count != 8'hFF) nz_count <= nz_count + 8'd1;
  end

endmodule

// File: doc/seu_stream.md
# seu_stream

Streaming, parametrised sign-extension and conversion unit for the pocket-calculator datapath. It takes IN_W-bit operands from the keypad/decoder side and produces OUT_W-bit two's-complement or magnitude words for the ALU. It supports four conversion modes, selected per operand. A valid/ready handshake, a 2-entry output FIFO and a saturating negative-zero event counter replace the old fixed 9→16 combinational path.

## Interface
- IN_W, 9: input operand width, including the sign bit; legal range is 2..31.
- OUT_W, 16: output width. It must be strictly greater than IN_W; elaboration fails otherwise.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high. It has priority over every other input.
- in_valid  in  1  upstream offers in_data/in_mode.
- in_ready  out  1  the block can accept an operand this cycle.
- in_data  in  IN_W  operand.
- in_mode  in  2  conversion mode, sampled together with in_data:
  - 00 SM: sign-magnitude to two's complement.
  - 01 TC: sign-extend.
  - 10 ZX: zero-extend.
  - 11 ABS: absolute value of a two's-complement operand.
- out_valid  out  1  the FIFO head is valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  OUT_W  converted word at the FIFO head.
- out_negzero  out  1  the head word came from an SM-mode negative zero.
- nz_count  out  8  number of accepted SM negative-zero operands, saturating.

## Operation
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- Conversion is performed at acceptance. The result {negzero, data} is written into the FIFO.
- Let s = in_data[IN_W-1], m = in_data[IN_W-2:0].
- SM mode:
  - s=0: result = m, zero-extended to OUT_W.
  - s=1 and m≠0: result = (~{zero-extended m}) + 1, i.e. −m in OUT_W bits.
  - s=1 and m=0: result = 0, negzero = 1.
- TC mode: result = in_data, sign-extended to OUT_W bits; negzero = 0.
- ZX mode: result = in_data, zero-extended to OUT_W bits; negzero = 0.
- ABS mode:
  - Treat in_data as two's complement. Result = |in_data|, zero-extended; negzero = 0.
  - The most negative input, −2^(IN_W−1), yields +2^(IN_W−1). This always fits because OUT_W > IN_W, so there is no saturation.
- FIFO: 2 entries, in-order, with occupancy count 0..2.
  - in_ready = (count ≠ 2). It is a function of registered count only; there is no combinational path from out_ready.
  - Push only: count +1. Pop only: count −1. Push and pop in the same cycle (count 1): count unchanged, and the new entry becomes the head on the next cycle.
  - When count = 2 no push is possible, even if out_ready = 1; in_ready rises the cycle after the pop.
- out_valid = (count ≠ 0).
- While out_valid = 0, out_data and out_negzero are forced to 0.
- out_data and out_negzero are held stable while out_valid = 1 and out_ready = 0.
- nz_count:
  - Increments by 1 on each accepted SM negative-zero operand.
  - Holds at 255 once reached.
  - It is not affected by pops.

## Timing
- Latency: an operand accepted at edge N is presented with out_valid = 1 after edge N, when the FIFO was empty. Throughput is 1 operand per cycle with out_ready held high.
- Reset values, visible after the first rising edge with rst = 1: count = 0, in_ready = 1, out_valid = 0, out_data = 0, out_negzero = 0, nz_count = 0. FIFO storage is cleared to 0.
- A handshake occurring in a cycle where rst = 1 is discarded: no push, no pop, no counter change.
- Reset mid-operation drops all buffered entries; no partial result survives.
- in_mode applies only to the operand it accompanies. Changing mode between operands needs no idle cycle.
- Upstream must hold in_data/in_mode stable while in_valid = 1 and in_ready = 0. The block does not check this.

## Test plan
All scenarios use IN_W=9, OUT_W=16.
- SM conversions, with out_ready=1:
  - 0x185 → 0xFF7B, negzero=0.
  - 0x085 → 0x0085.
  - 0x100 → 0x0000, negzero=1, and nz_count becomes 1.
  - Each output appears exactly one cycle after acceptance.
- TC/ZX/ABS on the same operand 0x185: TC → 0xFF85; ZX → 0x0185; ABS → 0x007B. Also ABS 0x100 → 0x0100 and ABS 0x1FF → 0x0001.
- Backpressure, with out_ready=0:
  - Offer A=0x001, B=0x002, C=0x003 in TC mode. A and B are accepted; in_ready drops; C is held.
  - Raise out_ready: outputs arrive in order 0x0001, 0x0002, 0x0003. in_ready rises the cycle after the first pop.
  - out_data is stable throughout the stall.
- Simultaneous push/pop at count 1 for 10 consecutive cycles: count stays 1, and no operand is lost or duplicated (scoreboard check).
- Counter saturation: 300 accepted SM 0x100 operands → nz_count = 255, and all 300 outputs are 0x0000 with negzero=1.
- Reset mid-operation: fill the FIFO with 2 entries, assert rst for 1 cycle while in_valid=1. Next cycle: out_valid=0, in_ready=1, nz_count=0, and the offered operand does not appear at the output.
